input_debouncer: RTL and testbench

- Conditions an asynchronous, bouncing input such as a push-button or external strobe into a clean, synchronous level.
- Sits directly upstream of the edge detector; its `level` output drives the detector's level input.
- Pipeline: a multi-flop synchronizer, then a counter-based stability filter. The filtered level changes only after the synchronized input has differed from it for a programmable number of consecutive cycles.

---
 rtl/input_debouncer.sv | 99 +++++++++
 tb/tb_input_debouncer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/input_debouncer.sv
// Debounces an asynchronous, bouncing input: a synchronizer chain followed by a
// consecutive-disagreement counter that must saturate before the clean level flips.
module input_debouncer #(
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter logic        INITIAL_DATA    = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw_in,
    output logic level,
    output logic changed,
    output logic busy
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_FILTER = 1'b1
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    state_e                 state_q, state_d;
    logic                   level_q, level_d;
    logic                   changed_q, changed_d;
    logic                   busy_q, busy_d;
    logic                   sync_s;

    assign sync_d = {sync_q[SYNC_STAGES-2:0], raw_in};
    assign sync_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= {SYNC_STAGES{INITIAL_DATA}};
            cnt_q     <= '0;
            state_q   <= ST_STABLE;
            level_q   <= INITIAL_DATA;
            changed_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            sync_q    <= sync_d;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            level_q   <= level_d;
            changed_q <= changed_d;
            busy_q    <= busy_d;
        end
    end

    // Any return of the synchronized input to the current level restarts the run.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        changed_d = 1'b0;

        case (state_q)
            ST_STABLE: begin
                cnt_d = '0;
                if (sync_s != level_q) begin
                    if (DEBOUNCE_CYCLES == 1) begin
                        level_d   = sync_s;
                        changed_d = 1'b1;
                    end else begin
                        cnt_d   = CNT_W'(1);
                        state_d = ST_FILTER;
                    end
                end
            end
            ST_FILTER: begin
                if (sync_s == level_q) begin
                    cnt_d   = '0;
                    state_d = ST_STABLE;
                end else if (cnt_q == CNT_LAST) begin
                    level_d   = sync_s;
                    changed_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_STABLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_STABLE;
            end
        endcase

        busy_d = (state_d == ST_FILTER);
    end

    assign level   = level_q;
    assign changed = changed_q;
    assign busy    = busy_q;

endmodule

// File: tb/tb_input_debouncer.sv
// Bench for input_debouncer: two configurations checked every cycle against a
// sliding-window model, plus hand-computed expectations per scenario.
module tb_input_debouncer;

    localparam int unsigned SS = 2;

    logic clk = 1'b0;
    logic rst_a, raw_a, level_a, changed_a, busy_a;
    logic rst_b, raw_b, level_b, changed_b, busy_b;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    input_debouncer #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .INITIAL_DATA(1'b0)) u_dut_a (
        .clk(clk), .rst(rst_a), .raw_in(raw_a),
        .level(level_a), .changed(changed_a), .busy(busy_a)
    );

    input_debouncer #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .INITIAL_DATA(1'b1)) u_dut_b (
        .clk(clk), .rst(rst_b), .raw_in(raw_b),
        .level(level_b), .changed(changed_b), .busy(busy_b)
    );

    // Model: s at an edge is raw from SS edges earlier; level flips when the
    // last D samples of s all disagree with it.
    bit rq [2][8];
    bit sq [2][16];
    bit m_level [2];
    bit m_changed [2];
    bit m_busy [2];

    function automatic int unsigned dcyc(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic bit initv(input int i);
        return (i == 0) ? 1'b0 : 1'b1;
    endfunction

    task automatic model_edge(input int i, input bit r, input bit rs);
        bit s;
        bit flip;
        int unsigned d;
        d = dcyc(i);
        if (rs) begin
            for (int j = 0; j < 8; j++) rq[i][j] = initv(i);
            for (int j = 0; j < 16; j++) sq[i][j] = initv(i);
            m_level[i]   = initv(i);
            m_changed[i] = 1'b0;
            m_busy[i]    = 1'b0;
        end else begin
            s = rq[i][0];
            for (int j = 0; j < int'(SS) - 1; j++) rq[i][j] = rq[i][j+1];
            rq[i][SS-1] = r;
            for (int j = 0; j < int'(d) - 1; j++) sq[i][j] = sq[i][j+1];
            sq[i][d-1] = s;
            flip = 1'b1;
            for (int j = 0; j < int'(d); j++) if (sq[i][j] == m_level[i]) flip = 1'b0;
            m_changed[i] = flip;
            m_busy[i]    = !flip && (s != m_level[i]);
            if (flip) m_level[i] = s;
        end
    endtask

    task automatic check(input string name, input logic act, input logic exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    endtask

    // Drive inputs, take one edge, advance the model, compare #1 after the edge.
    task automatic step(input bit ra, input bit rsa, input bit rb, input bit rsb);
        raw_a = ra; rst_a = rsa; raw_b = rb; rst_b = rsb;
        @(posedge clk);
        model_edge(0, ra, rsa);
        model_edge(1, rb, rsb);
        #1;
        check("a_level",   level_a,   m_level[0]);
        check("a_changed", changed_a, m_changed[0]);
        check("a_busy",    busy_a,    m_busy[0]);
        check("b_level",   level_b,   m_level[1]);
        check("b_changed", changed_b, m_changed[1]);
        check("b_busy",    busy_b,    m_busy[1]);
    endtask

    logic [6:0] bounce;

    initial begin
        bounce = 7'b1111011;
        raw_a = 1'b0; rst_a = 1'b1; raw_b = 1'b1; rst_b = 1'b1;

        step(0, 1, 1, 1);
        step(0, 1, 1, 1);
        check("rst_level_a",   level_a,   1'b0);
        check("rst_level_b",   level_b,   1'b1);
        check("rst_busy_a",    busy_a,    1'b0);
        check("rst_changed_a", changed_a, 1'b0);

        // Clean 0->1, held
        for (int e = 1; e <= 8; e++) begin
            step(1, 0, 1, 0);
            check("t1_busy",    busy_a,    (e >= 3 && e <= 5));
            check("t1_level",   level_a,   (e >= 6));
            check("t1_changed", changed_a, (e == 6));
        end

        step(0, 1, 1, 0);
        repeat (3) step(0, 0, 1, 0);

        // Short pulse of three samples is rejected
        for (int e = 1; e <= 12; e++) begin
            step(e <= 3, 0, 1, 0);
            check("t2_busy",    busy_a,    (e >= 3 && e <= 5));
            check("t2_level",   level_a,   1'b0);
            check("t2_changed", changed_a, 1'b0);
        end

        // Bounce restarts the count
        for (int e = 1; e <= 13; e++) begin
            step((e <= 7) ? bounce[e-1] : 1'b1, 0, 1, 0);
            check("t3_busy",    busy_a,    (e == 3 || e == 4 || (e >= 6 && e <= 8)));
            check("t3_level",   level_a,   (e >= 9));
            check("t3_changed", changed_a, (e == 9));
        end

        // 1->0 then immediate reversal 0->1
        for (int e = 1; e <= 16; e++) begin
            step(e >= 7, 0, 1, 0);
            check("t4_busy",    busy_a,    ((e >= 3 && e <= 5) || (e >= 9 && e <= 11)));
            check("t4_level",   level_a,   (e < 6 || e >= 12));
            check("t4_changed", changed_a, (e == 6 || e == 12));
        end

        step(0, 1, 1, 0);
        repeat (3) step(0, 0, 1, 0);

        // Reset in the middle of filtering
        for (int e = 1; e <= 12; e++) begin
            step(1, e == 4, 1, 0);
            check("t5_busy",    busy_a,    (e == 3 || (e >= 7 && e <= 9)));
            check("t5_level",   level_a,   (e >= 10));
            check("t5_changed", changed_a, (e == 10));
        end

        // Single-cycle filter, initial level 1
        for (int e = 1; e <= 6; e++) begin
            step(1, 0, 0, 0);
            check("t6_busy",    busy_b,    1'b0);
            check("t6_level",   level_b,   (e < 3));
            check("t6_changed", changed_b, (e == 3));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
